// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   - SZ_B/SZ_H/SZ_W/SZ_D : request size encodings
//   - lsu_state_e         : FSM states of load_store_unit
//   - LSU_LAT_LD          : accept-to-resp_valid edges for a load (accept edge counted)
//   - LSU_LAT_ST_D        : same, for a dword store
//   - size_mask()         : offset bits that must be zero for natural alignment
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  localparam int LSU_LAT_LD   = 3;
  localparam int LSU_LAT_ST_D = 2;

  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering between a 64-bit memory dword
// and a sub-dword access.
//   ld_dword_i  : dword read from memory
//   off_i       : byte offset of the lane (already aligned to size_i)
//   size_i      : SZ_B/SZ_H/SZ_W/SZ_D
//   unsigned_i  : 1 = zero-extend load, 0 = sign-extend
//   st_old_i    : previous memory dword for a store merge
//   st_wdata_i  : right-justified store data
//   ld_data_o   : extracted and extended load value
//   st_merged_o : st_old_i with the selected lane replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] ld_dword_i,
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [63:0] st_old_i,
  input  logic [63:0] st_wdata_i,
  output logic [63:0] ld_data_o,
  output logic [63:0] st_merged_o
);

  logic [5:0]  sh;
  logic [63:0] lane;
  logic [63:0] lane_mask;

  assign sh   = {off_i, 3'b000};
  assign lane = ld_dword_i >> sh;

  always_comb begin
    ld_data_o = lane;
    lane_mask = '1;
    case (size_i)
      SZ_B: begin
        ld_data_o = {{56{~unsigned_i & lane[7]}}, lane[7:0]};
        lane_mask = 64'h0000_0000_0000_00FF;
      end
      SZ_H: begin
        ld_data_o = {{48{~unsigned_i & lane[15]}}, lane[15:0]};
        lane_mask = 64'h0000_0000_0000_FFFF;
      end
      SZ_W: begin
        ld_data_o = {{32{~unsigned_i & lane[31]}}, lane[31:0]};
        lane_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        ld_data_o = lane;
        lane_mask = '1;
      end
    endcase
  end

  // Bytes outside the shifted lane mask keep their old value.
  assign st_merged_o = (st_old_i & ~(lane_mask << sh)) |
                       ((st_wdata_i << sh) & (lane_mask << sh));

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the 64-bit data-memory port.
// Accepts one load/store at a time, performs read-modify-write for sub-dword
// stores and extends sub-dword loads.
// Build option: LSU_MISALIGN_TRAP_EN -- misaligned requests return resp_err;
// when undefined the offset is masked down to natural alignment.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_wr/size/unsigned/addr/wdata : request fields, captured at accept
//   resp_valid/resp_ready      : response handshake, held until accepted
//   resp_rdata/resp_err        : load result (0 for stores/errors), error flag
//   mem_rd/mem_wr              : memory strobes (Moore decodes of state)
//   mem_addr/mem_wrdata        : dword index (zero-extended), write data
//   mem_rddata                 : read data, valid the cycle after mem_rd
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int IDX_W  = 16,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [63:0]       mem_addr,
  output logic [63:0]       mem_wrdata,
  input  logic [63:0]       mem_rddata
);

  lsu_state_e       state_q;
  logic             wr_q, uns_q, err_q;
  logic [1:0]       size_q;
  logic [2:0]       off_q;
  logic [IDX_W-1:0] idx_q;
  logic [63:0]      wdata_q, buf_q, rdata_q;

  logic [63:0] ld_data, st_merged;
  logic        range_err, misalign, req_err;

  // Any address bit above the dword index range is out of range.
  assign range_err = |(req_addr >> (IDX_W + 3));
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign  = |(req_addr[2:0] & size_mask(req_size));
`else
  assign misalign  = 1'b0;
`endif
  assign req_err   = range_err | misalign;

  lsu_lane_align u_align (
    .ld_dword_i  (mem_rddata),
    .off_i       (off_q),
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .st_old_i    (buf_q),
    .st_wdata_i  (wdata_q),
    .ld_data_o   (ld_data),
    .st_merged_o (st_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      off_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (req_valid) begin
          wr_q    <= req_wr;
          uns_q   <= req_unsigned;
          size_q  <= req_size;
          // Masking is a no-op for aligned requests; in the trap build any
          // misaligned request never reaches the memory anyway.
          off_q   <= req_addr[2:0] & ~size_mask(req_size);
          idx_q   <= req_addr[IDX_W+2:3];
          wdata_q <= req_wdata;
          rdata_q <= '0;
          err_q   <= req_err;
          // Dword stores write straight from the request; others get merged later.
          if (req_wr) buf_q <= req_wdata;
          if (req_err)                      state_q <= ST_RESP;
          else if (req_wr && req_size == SZ_D) state_q <= ST_WRITE;
          else                              state_q <= ST_READ;
        end
        ST_READ:    state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (wr_q) begin
            buf_q   <= mem_rddata;
            state_q <= ST_MERGE;
          end else begin
            rdata_q <= ld_data;
            state_q <= ST_RESP;
          end
        end
        ST_MERGE: begin
          buf_q   <= st_merged;
          state_q <= ST_WRITE;
        end
        ST_WRITE: state_q <= ST_RESP;
        ST_RESP:  if (resp_ready) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_rd     = (state_q == ST_READ);
  assign mem_wr     = (state_q == ST_WRITE);
  assign mem_addr   = {{(64-IDX_W){1'b0}}, idx_q};
  assign mem_wrdata = buf_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table of requests run through load_store_unit against a
// behavioural 64-bit memory with 1-cycle read latency; expected responses go
// through a scoreboard queue. Hand-written sequences cover response
// back-pressure and reset in the middle of an access.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_rd, mem_wr;
  logic [63:0] mem_addr, mem_wrdata;
  logic [63:0] mem_rddata = '0;

  always #5 clk = ~clk;

  load_store_unit #(.IDX_W(16), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata)
  );

  int errors = 0;
  int checks = 0;

  // Memory model plus strobe monitor.
  logic [63:0] mem [0:65535];
  int          rd_cnt = 0, wr_cnt = 0;
  logic [63:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;

  always @(posedge clk) begin
    if (mem_rd || mem_wr) begin
      checks++;
      if ((mem_rd && mem_wr) || mem_addr > 64'hFFFF) begin
        errors++;
        $display("FAIL strobe: rd=%0b wr=%0b addr=%h, required exclusive strobes and index < 65536",
                 mem_rd, mem_wr, mem_addr);
      end
    end
    if (mem_rd) begin
      rd_cnt++;
      last_rd_addr = mem_addr;
      mem_rddata <= mem[mem_addr[15:0]];
    end
    if (mem_wr) begin
      wr_cnt++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wrdata;
      mem[mem_addr[15:0]] <= mem_wrdata;
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [63:0] exp_maddr;
    logic [63:0] exp_wdat;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  localparam int LAT_ST_SUB = 5;
  localparam int LAT_ERR    = 1;

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_rd, input int exp_wr,
                              input logic [63:0] exp_maddr, input logic [63:0] exp_wdat);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_maddr = exp_maddr; v.exp_wdat = exp_wdat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: response with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".rdata"}, resp_rdata, e.rdata);
      chk({name, ".err"}, {63'b0, resp_err}, {63'b0, e.err});
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid = 1'b1; req_wr = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
  endtask

  task automatic scramble();
    req_valid = 1'b0; req_wr = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int lat, rd0, wr0;
    string nm;
    nm = $sformatf("vec%0d", n);
    @(negedge clk);
    chk({nm, ".req_ready"}, {63'b0, req_ready}, 64'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    drive(v);
    sb.push_back('{v.exp_rdata, v.exp_err});
    @(posedge clk); #1;
    scramble();
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL %s.timeout: no resp_valid after %0d edges, required %0d", nm, lat, v.exp_lat);
      void'(sb.pop_front());
    end else begin
      pop_chk(nm);
    end
    chk({nm, ".latency"}, 64'(lat), 64'(v.exp_lat));
    chk({nm, ".rd_count"}, 64'(rd_cnt - rd0), 64'(v.exp_rd));
    chk({nm, ".wr_count"}, 64'(wr_cnt - wr0), 64'(v.exp_wr));
    if (v.exp_rd > 0) chk({nm, ".rd_addr"}, last_rd_addr, v.exp_maddr);
    if (v.exp_wr > 0) begin
      chk({nm, ".wr_addr"}, last_wr_addr, v.exp_maddr);
      chk({nm, ".wr_data"}, last_wr_data, v.exp_wdat);
    end
    @(posedge clk); #1;  // response handshake (resp_ready high)
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;
    int          wr0, n;

    for (int i = 0; i < 65536; i++) mem[i] = '0;

    vecs.push_back(mk(1, SZ_D, 0, 64'h10, 64'h1122334455667788, 0, 0, LSU_LAT_ST_D, 0, 1, 2, 64'h1122334455667788));
    vecs.push_back(mk(1, SZ_B, 0, 64'h13, 64'h000000000000CDAB, 0, 0, LAT_ST_SUB, 1, 1, 2, 64'h11223344AB667788));
    vecs.push_back(mk(0, SZ_B, 0, 64'h13, 0, 64'hFFFFFFFFFFFFFFAB, 0, LSU_LAT_LD, 1, 0, 2, 0));
    vecs.push_back(mk(0, SZ_B, 1, 64'h13, 0, 64'h00000000000000AB, 0, LSU_LAT_LD, 1, 0, 2, 0));
    vecs.push_back(mk(0, SZ_H, 0, 64'h16, 0, 64'h0000000000001122, 0, LSU_LAT_LD, 1, 0, 2, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, SZ_W, 1, 64'h12, 0, 64'h0, 1, LAT_ERR, 0, 0, 0, 0));
`else
    vecs.push_back(mk(0, SZ_W, 1, 64'h12, 0, 64'h00000000AB667788, 0, LSU_LAT_LD, 1, 0, 2, 0));
`endif
    vecs.push_back(mk(0, SZ_D, 0, 64'h80000, 0, 64'h0, 1, LAT_ERR, 0, 0, 0, 0));
    vecs.push_back(mk(1, SZ_D, 0, 64'hFFFF000000000010, 64'h5555, 0, 1, LAT_ERR, 0, 0, 0, 0));
    vecs.push_back(mk(1, SZ_H, 0, 64'h1A, 64'h0000000000008001, 0, 0, LAT_ST_SUB, 1, 1, 3, 64'h0000000080010000));
    vecs.push_back(mk(0, SZ_H, 0, 64'h1A, 0, 64'hFFFFFFFFFFFF8001, 0, LSU_LAT_LD, 1, 0, 3, 0));
    vecs.push_back(mk(0, SZ_W, 0, 64'h18, 0, 64'hFFFFFFFF80010000, 0, LSU_LAT_LD, 1, 0, 3, 0));
    vecs.push_back(mk(1, SZ_W, 0, 64'h14, 64'h12345678DEADBEEF, 0, 0, LAT_ST_SUB, 1, 1, 2, 64'hDEADBEEFAB667788));
    vecs.push_back(mk(0, SZ_D, 0, 64'h10, 0, 64'hDEADBEEFAB667788, 0, LSU_LAT_LD, 1, 0, 2, 0));
    vecs.push_back(mk(0, SZ_W, 1, 64'h14, 0, 64'h00000000DEADBEEF, 0, LSU_LAT_LD, 1, 0, 2, 0));
    vecs.push_back(mk(0, SZ_W, 0, 64'h14, 0, 64'hFFFFFFFFDEADBEEF, 0, LSU_LAT_LD, 1, 0, 2, 0));
    vecs.push_back(mk(0, SZ_B, 1, 64'h17, 0, 64'h00000000000000DE, 0, LSU_LAT_LD, 1, 0, 2, 0));
    vecs.push_back(mk(0, SZ_B, 0, 64'h17, 0, 64'hFFFFFFFFFFFFFFDE, 0, LSU_LAT_LD, 1, 0, 2, 0));
    vecs.push_back(mk(1, SZ_D, 0, 64'h7FFF8, 64'hA5A5A5A55A5A5A5A, 0, 0, LSU_LAT_ST_D, 0, 1, 64'hFFFF, 64'hA5A5A5A55A5A5A5A));
    vecs.push_back(mk(0, SZ_D, 0, 64'h7FFF8, 0, 64'hA5A5A5A55A5A5A5A, 0, LSU_LAT_LD, 1, 0, 64'hFFFF, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, SZ_D, 1, 64'h7FFFD, 0, 64'h0, 1, LAT_ERR, 0, 0, 0, 0));
`else
    vecs.push_back(mk(0, SZ_D, 1, 64'h7FFFD, 0, 64'hA5A5A5A55A5A5A5A, 0, LSU_LAT_LD, 1, 0, 64'hFFFF, 0));
`endif

    // Reset state.
    rst_n = 1'b0; resp_ready = 1'b1; scramble();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready",  {63'b0, req_ready},  64'd1);
    chk("rst.resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst.resp_err",   {63'b0, resp_err},   64'd0);
    chk("rst.resp_rdata", resp_rdata, 64'd0);
    chk("rst.mem_strobe", {62'b0, mem_rd, mem_wr}, 64'd0);
    chk("rst.mem_addr",   mem_addr,   64'd0);
    chk("rst.mem_wrdata", mem_wrdata, 64'd0);
    rst_n = 1'b1;

    n = 0;
    foreach (vecs[i]) begin
      run_vec(vecs[i], n);
      n++;
    end

    // Back-pressure: response must hold while resp_ready is low.
    @(negedge clk);
    resp_ready = 1'b0;
    drive(mk(0, SZ_B, 0, 64'h13, 0, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back('{64'hFFFFFFFFFFFFFFAB, 1'b0});
    @(posedge clk); #1;
    scramble();
    for (int i = 0; i < 20 && !resp_valid; i++) begin
      @(posedge clk); #1;
    end
    held = resp_rdata;
    chk("hold.first_rdata", held, 64'hFFFFFFFFFFFFFFAB);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold.resp_valid", {63'b0, resp_valid}, 64'd1);
      chk("hold.resp_rdata", resp_rdata, held);
      chk("hold.req_ready",  {63'b0, req_ready},  64'd0);
    end
    pop_chk("hold");
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold.release_valid", {63'b0, resp_valid}, 64'd0);
    chk("hold.release_ready", {63'b0, req_ready},  64'd1);

    // Reset while a byte store sits in READ: abort, no write, no response.
    @(negedge clk);
    drive(mk(1, SZ_B, 0, 64'h1B, 64'h77, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    scramble();
    chk("rstmid.in_read", {63'b0, mem_rd}, 64'd1);
    wr0 = wr_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmid.req_ready",  {63'b0, req_ready},  64'd1);
    chk("rstmid.resp_valid", {63'b0, resp_valid}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rstmid.idle_no_resp", {62'b0, resp_valid, mem_wr}, 64'd0);
    end
    chk("rstmid.wr_count", 64'(wr_cnt - wr0), 64'd0);
    run_vec(mk(0, SZ_D, 0, 64'h18, 0, 64'h0000000080010000, 0, LSU_LAT_LD, 1, 0, 3, 0), 100);

    chk("scoreboard.empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
